// File: rtl/ram_alpha_reader.sv
// rtl/ram_alpha_reader.sv - alpha RAM read sequencer with wrap-around addressing and a 2-entry stream buffer
// Optional running sum of transferred alphas is enabled by defining ALPHA_READ_SUM_EN.
module ram_alpha_reader #(
   parameter int NUM_QUBIT = 3,
   parameter int ALPHA_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [NUM_QUBIT-1:0] start_addr,
   input  logic [NUM_QUBIT:0]   count,
   output logic [NUM_QUBIT-1:0] read_address,
   input  logic [ALPHA_W-1:0]   read_alpha,
   output logic [ALPHA_W-1:0]   alpha_out,
   output logic                 alpha_valid,
   input  logic                 alpha_ready,
   output logic                 alpha_last,
   output logic                 busy,
   output logic                 done
`ifdef ALPHA_READ_SUM_EN
   ,
   output logic [ALPHA_W+NUM_QUBIT-1:0] alpha_sum
`endif
);

   localparam logic [NUM_QUBIT:0]   LEN_ONE  = {{NUM_QUBIT{1'b0}}, 1'b1};
   localparam logic [NUM_QUBIT:0]   LEN_FULL = {1'b1, {NUM_QUBIT{1'b0}}};
   localparam logic [NUM_QUBIT-1:0] ADDR_ONE = {{(NUM_QUBIT-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t               state, state_nxt;
   logic [NUM_QUBIT-1:0] addr, last_addr;
   logic [NUM_QUBIT:0]   remaining, len, xfer_idx;
   logic                 in_flight;
   logic [ALPHA_W-1:0]   buf_mem [2];
   logic                 rd_ptr, wr_ptr;
   logic [1:0]           occ;
   logic [2:0]           credit_load;
   logic                 start_ok, issue, push, pop, last_xfer;

   assign start_ok     = (state == S_IDLE) && start;
   assign push         = in_flight;
   assign alpha_valid  = (occ != 2'd0);
   assign pop          = alpha_valid && alpha_ready;
   // A head leaving this cycle frees its slot, which keeps the stream at one element per cycle.
   assign credit_load  = {1'b0, occ} + {2'b0, in_flight} - {2'b0, pop};
   assign issue        = (state == S_ISSUE) && (credit_load < 3'd2);
   assign read_address = issue ? addr : last_addr;
   assign alpha_out    = buf_mem[rd_ptr];
   assign alpha_last   = alpha_valid && (xfer_idx == len - LEN_ONE);
   assign last_xfer    = pop && alpha_last;
   assign busy         = (state == S_ISSUE) || (state == S_DRAIN);
   assign done         = (state == S_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_ISSUE;
         S_ISSUE: if (issue && remaining == LEN_ONE) state_nxt = S_DRAIN;
         S_DRAIN: if (last_xfer) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr       <= '0;
         last_addr  <= '0;
         remaining  <= '0;
         len        <= '0;
         xfer_idx   <= '0;
         in_flight  <= 1'b0;
         buf_mem[0] <= '0;
         buf_mem[1] <= '0;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         occ        <= 2'd0;
      end else begin
         if (start_ok) begin
            addr      <= start_addr;
            remaining <= (count == '0) ? LEN_FULL : count;
            len       <= (count == '0) ? LEN_FULL : count;
         end
         if (issue) begin
            addr      <= addr + ADDR_ONE;
            last_addr <= addr;
            remaining <= remaining - LEN_ONE;
         end
         // RAM data lands one cycle after the address, so the flag marks the capture cycle.
         in_flight <= issue;
         if (push) begin
            buf_mem[wr_ptr] <= read_alpha;
            wr_ptr          <= ~wr_ptr;
         end
         if (start_ok)
            xfer_idx <= '0;
         else if (pop)
            xfer_idx <= xfer_idx + LEN_ONE;
         if (pop)
            rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

`ifdef ALPHA_READ_SUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         alpha_sum <= '0;
      else if (start_ok)
         alpha_sum <= '0;
      else if (pop)
         alpha_sum <= alpha_sum + {{NUM_QUBIT{1'b0}}, alpha_out};
   end
`endif

endmodule

// File: tb/tb_ram_alpha_reader.sv
// tb/tb_ram_alpha_reader.sv - randomized self-checking bench for ram_alpha_reader
// Sum checks are compiled in when ALPHA_READ_SUM_EN is defined.
`timescale 1ns/1ps
module tb_ram_alpha_reader;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst, start, alpha_ready;
   logic [2:0] start_addr, read_address;
   logic [3:0] count;
   logic [7:0] read_alpha, alpha_out;
   logic       alpha_valid, alpha_last, busy, done;
`ifdef ALPHA_READ_SUM_EN
   logic [10:0] alpha_sum;
`endif

   logic [7:0] mem [DEPTH];
   int checks = 0;
   int failures = 0;

   logic [7:0] got_d [$];
   bit         got_l [$];
   int         got_c [$];
   logic [2:0] addr_seq [$];
   int         stall_err, busy_err, first_valid, done_cyc;
   logic [10:0] sum_at_done;

   always #5 clk = ~clk;

   always_ff @(posedge clk) read_alpha <= mem[read_address];

   ram_alpha_reader #(.NUM_QUBIT(3), .ALPHA_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
      .read_address(read_address), .read_alpha(read_alpha), .alpha_out(alpha_out),
      .alpha_valid(alpha_valid), .alpha_ready(alpha_ready), .alpha_last(alpha_last),
      .busy(busy), .done(done)
`ifdef ALPHA_READ_SUM_EN
      , .alpha_sum(alpha_sum)
`endif
   );

   function automatic logic [7:0] exp_at(input logic [2:0] sa, input int i);
      return mem[(int'(sa) + i) % DEPTH];
   endfunction

   function automatic int exp_len(input logic [3:0] cnt);
      return (cnt == 4'd0) ? DEPTH : int'(cnt);
   endfunction

   function automatic logic [10:0] exp_sum(input logic [2:0] sa, input logic [3:0] cnt);
      int s = 0;
      for (int i = 0; i < exp_len(cnt); i++) s += int'(exp_at(sa, i));
      return 11'(s);
   endfunction

   // mode 0: ready held high; 1: fixed 1,0,0,1,0,1 pattern; 2: random ready.
   task automatic do_run(input logic [2:0] sa, input logic [3:0] cnt, input int mode,
                         input int mid_at, input int rst_xfer, output bit timed_out);
      int cyc;
      bit prev_stall;
      logic [7:0] prev_data;
      logic [2:0] last_ra;
      int pat [6] = '{1, 0, 0, 1, 0, 1};
      got_d.delete(); got_l.delete(); got_c.delete(); addr_seq.delete();
      stall_err = 0; busy_err = 0; first_valid = -1; done_cyc = -1; sum_at_done = '0;
      timed_out = 1'b0; prev_stall = 1'b0; prev_data = '0;
      @(negedge clk);
      start_addr = sa; count = cnt; start = 1'b1;
      if (mode == 0) alpha_ready = 1'b1;
      last_ra = read_address;
      for (cyc = 1; cyc <= 400; cyc++) begin
         @(negedge clk);
         start = (cyc == mid_at);
         if (cyc == mid_at) begin
            start_addr = sa + 3'd3;
            count = 4'd2;
         end
         case (mode)
            0:       alpha_ready = 1'b1;
            1:       alpha_ready = (pat[cyc % 6] == 1);
            default: alpha_ready = ($urandom_range(0, 1) == 1);
         endcase
         #1;
         if (read_address != last_ra) begin
            addr_seq.push_back(read_address);
            last_ra = read_address;
         end
         if (alpha_valid && first_valid < 0) first_valid = cyc;
         if (prev_stall && (!alpha_valid || alpha_out !== prev_data)) stall_err++;
         if (done) begin
            done_cyc = cyc;
`ifdef ALPHA_READ_SUM_EN
            sum_at_done = alpha_sum;
`endif
            if (busy) busy_err++;
            break;
         end
         if (!busy) busy_err++;
         if (rst_xfer >= 0 && got_d.size() == rst_xfer && alpha_valid) begin
            rst = 1'b1;
            #1;
            return;
         end
         if (alpha_valid && alpha_ready) begin
            got_d.push_back(alpha_out);
            got_l.push_back(alpha_last);
            got_c.push_back(cyc);
         end
         prev_stall = alpha_valid && !alpha_ready;
         prev_data = alpha_out;
      end
      if (cyc > 400) timed_out = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; alpha_ready = 1'b0; start_addr = '0; count = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({alpha_valid, alpha_last, busy, done} !== 4'b0000) begin
         failures++; $display("FAIL reset_flags got=%b exp=0000", {alpha_valid, alpha_last, busy, done});
      end
      checks++;
      if (alpha_out !== 8'h00) begin failures++; $display("FAIL reset_alpha_out got=%0h exp=0", alpha_out); end
      checks++;
      if (read_address !== 3'd0) begin failures++; $display("FAIL reset_read_address got=%0d exp=0", read_address); end
      rst = 1'b0;
   endtask

   task automatic test_full_wrap();
      bit to;
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i + 8'h10);
      do_run(3'd0, 4'd0, 0, -1, -1, to);
      checks++;
      if (to) begin failures++; $display("FAIL full_timeout got=timeout exp=done"); end
      checks++;
      if (got_d.size() != 8) begin failures++; $display("FAIL full_len got=%0d exp=8", got_d.size()); end
      for (int i = 0; i < got_d.size() && i < 8; i++) begin
         checks++;
         if (got_d[i] !== 8'(8'h10 + i) || got_l[i] !== (i == 7) || got_c[i] != 3 + i) begin
            failures++;
            $display("FAIL full_elem%0d got=%0h/%0b/c%0d exp=%0h/%0b/c%0d", i, got_d[i], got_l[i], got_c[i], 8'h10 + i, i == 7, 3 + i);
         end
      end
      checks++;
      if (first_valid != 3) begin failures++; $display("FAIL full_latency got=%0d exp=3", first_valid); end
      checks++;
      if (got_c.size() > 0 && done_cyc != got_c[got_c.size()-1] + 1) begin
         failures++; $display("FAIL full_done_cycle got=%0d exp=%0d", done_cyc, got_c[got_c.size()-1] + 1);
      end
      checks++;
      if (busy_err != 0) begin failures++; $display("FAIL full_busy got=%0d exp=0", busy_err); end
      @(negedge clk); #1;
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL full_done_width got=%b exp=0", done); end
   endtask

   task automatic test_wrap_offset();
      bit to;
      logic [2:0] exp_a [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
      do_run(3'd6, 4'd4, 0, -1, -1, to);
      checks++;
      if (to || got_d.size() != 4 || addr_seq.size() != 4) begin
         failures++; $display("FAIL wrap_len got=%0d/%0d to=%0b exp=4/4", got_d.size(), addr_seq.size(), to);
      end
      for (int i = 0; i < 4 && i < got_d.size() && i < addr_seq.size(); i++) begin
         checks++;
         if (addr_seq[i] !== exp_a[i] || got_d[i] !== exp_at(3'd6, i) || got_c[i] != got_c[0] + i) begin
            failures++;
            $display("FAIL wrap_elem%0d got=a%0d/%0h/c%0d exp=a%0d/%0h/c%0d", i, addr_seq[i], got_d[i], got_c[i], exp_a[i], exp_at(3'd6, i), got_c[0] + i);
         end
      end
   endtask

   task automatic test_backpressure();
      bit to;
      logic [2:0] sa;
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
      sa = 3'($urandom);
      do_run(sa, 4'd8, 1, -1, -1, to);
      checks++;
      if (to || got_d.size() != 8) begin failures++; $display("FAIL bp_len got=%0d to=%0b exp=8", got_d.size(), to); end
      for (int i = 0; i < got_d.size() && i < 8; i++) begin
         checks++;
         if (got_d[i] !== exp_at(sa, i) || got_l[i] !== (i == 7)) begin
            failures++; $display("FAIL bp_elem%0d got=%0h/%0b exp=%0h/%0b", i, got_d[i], got_l[i], exp_at(sa, i), i == 7);
         end
      end
      checks++;
      if (stall_err != 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stall_err); end
   endtask

   task automatic test_restart_ignored();
      bit to;
      do_run(3'd2, 4'd5, 1, 5, -1, to);
      checks++;
      if (to || got_d.size() != 5) begin failures++; $display("FAIL restart_len got=%0d to=%0b exp=5", got_d.size(), to); end
      for (int i = 0; i < got_d.size() && i < 5; i++) begin
         checks++;
         if (got_d[i] !== exp_at(3'd2, i) || got_l[i] !== (i == 4)) begin
            failures++; $display("FAIL restart_elem%0d got=%0h exp=%0h", i, got_d[i], exp_at(3'd2, i));
         end
      end
      do_run(3'd5, 4'd2, 0, -1, -1, to);
      checks++;
      if (to || got_d.size() != 2 || got_d[0] !== exp_at(3'd5, 0) || got_d[1] !== exp_at(3'd5, 1)) begin
         failures++; $display("FAIL restart_next got=%0d elems to=%0b exp=2 from addr 5", got_d.size(), to);
      end
   endtask

   task automatic test_reset_mid();
      bit to;
      int seen_done = 0;
      do_run(3'd1, 4'd6, 0, -1, 2, to);
      checks++;
      if (rst !== 1'b1) begin failures++; $display("FAIL rstmid_reached got=%b exp=1", rst); end
      checks++;
      if ({alpha_valid, alpha_last, busy, done, alpha_out} !== 12'h000) begin
         failures++; $display("FAIL rstmid_outputs got=%0h exp=0", {alpha_valid, alpha_last, busy, done, alpha_out});
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk); #1;
         if (done || busy || alpha_valid) seen_done++;
      end
      checks++;
      if (seen_done != 0) begin failures++; $display("FAIL rstmid_quiet got=%0d exp=0", seen_done); end
      do_run(3'd3, 4'd0, 2, -1, -1, to);
      checks++;
      if (to || got_d.size() != 8) begin failures++; $display("FAIL rstmid_fresh_len got=%0d to=%0b exp=8", got_d.size(), to); end
      for (int i = 0; i < got_d.size() && i < 8; i++) begin
         checks++;
         if (got_d[i] !== exp_at(3'd3, i)) begin
            failures++; $display("FAIL rstmid_fresh%0d got=%0h exp=%0h", i, got_d[i], exp_at(3'd3, i));
         end
      end
   endtask

   task automatic test_random();
      bit to;
      logic [2:0] sa;
      logic [3:0] cnt;
      int n;
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
         sa = 3'($urandom);
         cnt = 4'($urandom_range(0, 8));
         n = exp_len(cnt);
         do_run(sa, cnt, 2, -1, -1, to);
         checks++;
         if (to || got_d.size() != n || stall_err != 0 || busy_err != 0) begin
            failures++;
            $display("FAIL rand%0d_run got=len%0d stall%0d busy%0d to%0b exp=len%0d", r, got_d.size(), stall_err, busy_err, to, n);
         end
         for (int i = 0; i < got_d.size() && i < n; i++) begin
            checks++;
            if (got_d[i] !== exp_at(sa, i) || got_l[i] !== (i == n - 1)) begin
               failures++; $display("FAIL rand%0d_elem%0d got=%0h/%0b exp=%0h/%0b", r, i, got_d[i], got_l[i], exp_at(sa, i), i == n - 1);
            end
         end
`ifdef ALPHA_READ_SUM_EN
         checks++;
         if (sum_at_done !== exp_sum(sa, cnt)) begin
            failures++; $display("FAIL rand%0d_sum got=%0h exp=%0h", r, sum_at_done, exp_sum(sa, cnt));
         end
`endif
      end
   endtask

`ifdef ALPHA_READ_SUM_EN
   task automatic test_sum();
      bit to;
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'hFF;
      do_run(3'd0, 4'd0, 0, -1, -1, to);
      checks++;
      if (to || sum_at_done !== 11'h7F8) begin
         failures++; $display("FAIL sum_all_ff got=%0h to=%0b exp=7f8", sum_at_done, to);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
      test_reset();
      test_full_wrap();
      test_wrap_offset();
      test_backpressure();
      test_restart_ignored();
      test_reset_mid();
      test_random();
`ifdef ALPHA_READ_SUM_EN
      test_sum();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
